// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for the single read port of the 4-entry register bank.
// Optional owner locking is enabled by defining ARB_LOCK_EN.
module regfile_read_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [7:0]        req_reg_no,
    output logic [3:0]        grant,
    output logic [1:0]        reg_no,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        rd_id
`ifdef ARB_LOCK_EN
    ,
    input  logic [3:0]        req_lock
`endif
);

    if (LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_lock_max_check
        $error("LOCK_MAX must be in 1..15");
    end

    logic [1:0] rr_ptr;
    logic       issue_v;
    logic [1:0] issue_id;

    logic       rr_found;
    logic [1:0] rr_win;
    logic [1:0] scan_idx;
    logic       win_v;
    logic [1:0] win;

    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!rr_found && req[scan_idx]) begin
                rr_found = 1'b1;
                rr_win   = scan_idx;
            end
        end
    end

`ifdef ARB_LOCK_EN
    logic [3:0] lock_cnt;
    logic       hold;

    // The owner is whoever was granted last cycle; the count includes its first grant.
    assign hold  = issue_v && req[issue_id] && req_lock[issue_id] && (lock_cnt < 4'(LOCK_MAX));
    assign win_v = hold || rr_found;
    assign win   = hold ? issue_id : rr_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (hold) begin
            lock_cnt <= lock_cnt + 4'd1;
        end else if (rr_found && req_lock[rr_win]) begin
            lock_cnt <= 4'd1;
        end else begin
            lock_cnt <= '0;
        end
    end
`else
    assign win_v = rr_found;
    assign win   = rr_win;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant    <= '0;
            reg_no   <= '0;
            rr_ptr   <= '0;
            issue_v  <= 1'b0;
            issue_id <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_id    <= '0;
        end else begin
            if (win_v) begin
                grant    <= 4'b0001 << win;
                reg_no   <= req_reg_no[{win, 1'b0} +: 2];
                issue_v  <= 1'b1;
                issue_id <= win;
                rr_ptr   <= win + 2'd1;
            end else begin
                grant    <= '0;
                issue_v  <= 1'b0;
            end
            rd_valid <= issue_v;
            if (issue_v) begin
                rd_data <= reg_data;
                rd_id   <= issue_id;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: directed requests push expected
// grants/reads; a negedge monitor pops and compares whenever the DUT presents them.
module tb_regfile_read_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_reg_no;
    logic [3:0]  grant;
    logic [1:0]  reg_no;
    logic [31:0] reg_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [1:0]  rd_id;
`ifdef ARB_LOCK_EN
    logic [3:0]  req_lock;
`endif

    logic [31:0] bank [4];
    assign reg_data = bank[reg_no];

    regfile_read_arbiter #(.DATA_W(32), .LOCK_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_reg_no (req_reg_no),
        .grant      (grant),
        .reg_no     (reg_no),
        .reg_data   (reg_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_id      (rd_id)
`ifdef ARB_LOCK_EN
        ,
        .req_lock   (req_lock)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] g;
        logic [1:0] rn;
    } gexp_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests; id < 0 means no grant is expected.
    task automatic issue(input logic [3:0] r, input logic [7:0] rn, input int id, input logic [1:0] ereg);
        gexp_t ge;
        rexp_t re;
        req        = r;
        req_reg_no = rn;
        if (id >= 0) begin
            ge.g    = 4'(4'b0001 << id);
            ge.rn   = ereg;
            re.id   = 2'(id);
            re.data = bank[ereg];
            gq.push_back(ge);
            rq.push_back(re);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},    32'(grant),    32'd0);
        check({tag, "_reg_no"},   32'(reg_no),   32'd0);
        check({tag, "_rd_data"},  rd_data,       32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_id"},    32'(rd_id),    32'd0);
    endtask

    always @(negedge clk) begin : monitor
        gexp_t ge;
        rexp_t re;
        if (!reset) begin
            if (grant != 4'd0) begin
                if (gq.size() == 0) begin
                    check("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    ge = gq.pop_front();
                    check("grant",  32'(grant),  32'(ge.g));
                    check("reg_no", 32'(reg_no), 32'(ge.rn));
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
                end else begin
                    re = rq.pop_front();
                    check("rd_id",   32'(rd_id), 32'(re.id));
                    check("rd_data", rd_data,    re.data);
                end
            end
        end
    end

    int          fair_id  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [1:0]  fair_reg [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        bank[0] = 32'h1111_0000;
        bank[1] = 32'h2222_0001;
        bank[2] = 32'h3333_0002;
        bank[3] = 32'hDEAD_BEEF;
        reset      = 1'b1;
        req        = '0;
        req_reg_no = '0;
`ifdef ARB_LOCK_EN
        req_lock   = '0;
`endif
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset = 1'b0;

        // single request: requester 2 reads register 3
        issue(4'b0100, 8'b00_11_00_00, 2, 2'd3);
        issue(4'b0000, 8'b00_11_00_00, -1, 2'd0);
        issue(4'b0000, 8'b00_11_00_00, -1, 2'd0);

        // fairness from a fresh pointer
        do_reset();
        for (int k = 0; k < 8; k++)
            issue(4'b1111, 8'b00_11_10_01, fair_id[k], fair_reg[k]);

        // pointer at 0 after requester 3: 0 first, then 3
        issue(4'b1001, 8'b10_00_00_11, 0, 2'd3);
        issue(4'b1000, 8'b10_00_00_11, 3, 2'd2);

        // idle gap: reg_no holds requester 3's select
        for (int k = 0; k < 3; k++) begin
            issue(4'b0000, 8'b10_00_00_11, -1, 2'd0);
            check("gap_grant",  32'(grant),  32'd0);
            check("gap_reg_no", 32'(reg_no), 32'd2);
            if (k > 0) check("gap_rd_valid", 32'(rd_valid), 32'd0);
        end
        issue(4'b0010, 8'b10_00_00_11, 1, 2'd0);
        issue(4'b0000, 8'b10_00_00_11, -1, 2'd0);
        issue(4'b0000, 8'b10_00_00_11, -1, 2'd0);

        // reset in the cycle after a grant: read discarded, pointer back to 0
        issue(4'b0100, 8'b10_00_00_11, 2, 2'd0);
        reset = 1'b1;
        gq.delete();
        rq.delete();
        req = 4'b0000;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #2;
        reset = 1'b0;
        issue(4'b1010, 8'b10_00_00_11, 1, 2'd0);
        for (int k = 0; k < 3; k++)
            issue(4'b0000, 8'b10_00_00_11, -1, 2'd0);

`ifdef ARB_LOCK_EN
        do_reset();
        req_lock = 4'b0010;
        for (int k = 0; k < 4; k++)
            issue(4'b0110, 8'b00_00_10_01, 1, 2'd2);
        issue(4'b0110, 8'b00_00_10_01, 2, 2'd0);
        req_lock = 4'b0000;
        for (int k = 0; k < 3; k++)
            issue(4'b0000, 8'b00_00_10_01, -1, 2'd0);
`endif

        repeat (3) @(posedge clk);
        #2;
        check("grant_queue_drained", 32'(gq.size()), 32'd0);
        check("read_queue_drained",  32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
